// File: rtl/mv_result_drain.sv
// mv_result_drain: snapshots every MAC node result on a capture strobe, then
// streams the held results out as sign-extended AXI4-Stream beats, node 0 first.
// The array is free to clear and start the next row right after the capture.

module mv_result_drain #(
  parameter int NUM_NODES = 8,
  parameter int RES_W     = 25,
  parameter int OUT_W     = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       capture,
  input  logic [NUM_NODES*RES_W-1:0] res_bus,
  output logic [OUT_W-1:0]           m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic                       busy,
  output logic                       overrun,
  input  logic                       clr_overrun,
  output logic [15:0]                frame_cnt
);

  localparam int               IDX_W    = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [RES_W-1:0] shadow_q [NUM_NODES];

  logic             load;       // snapshot res_bus into the shadow bank this cycle
  logic             beat;       // a word is handed over this cycle
  logic             last_beat;  // the handed-over word is the last node's
  logic             drop;       // capture arrives while a frame is still held
  logic [RES_W-1:0] cur_res;

  // Every output comes straight from state/index/shadow flops, so m_tvalid
  // never depends combinationally on m_tready.
  assign m_tvalid  = (state_q == S_DRAIN);
  assign busy      = (state_q == S_DRAIN);
  assign m_tlast   = (idx_q == LAST_IDX);
  assign cur_res   = shadow_q[idx_q];
  // Signed cast sign-extends the held word to the stream width.
  assign m_tdata   = OUT_W'($signed(cur_res));
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

  assign beat      = m_tvalid & m_tready;
  assign last_beat = beat & (idx_q == LAST_IDX);
  // A capture during DRAIN is only taken on the final beat (back-to-back).
  assign drop      = capture & (state_q == S_DRAIN) & ~last_beat;

  // Next-state, index, frame counter and sticky overrun logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    load        = 1'b0;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (capture) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_beat) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (capture) begin
            load  = 1'b1;
            idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (beat) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A dropped capture outranks a simultaneous clear.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // Control registers; reset discards any frame in flight.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    if (!rstn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Shadow bank: one-cycle snapshot of all node results.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: this bank is reset because m_tdata must read zero out of reset;
    // a storage array that is never observed before being written would not need it.
    if (!rstn) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        shadow_q[i] <= res_bus[i*RES_W +: RES_W];
      end
    end
  end

endmodule

// File: tb/tb_mv_result_drain.sv
// Bench for mv_result_drain: a scoreboard queue of expected {tlast, tdata}
// beats is filled when a capture is driven and drained by a monitor that
// samples the stream on the falling clock edge.

module tb_mv_result_drain;

  localparam int NUM_NODES = 8;
  localparam int RES_W     = 25;
  localparam int OUT_W     = 32;

  logic                       clk;
  logic                       rstn;
  logic                       capture;
  logic [NUM_NODES*RES_W-1:0] res_bus;
  logic [OUT_W-1:0]           m_tdata;
  logic                       m_tvalid;
  logic                       m_tready;
  logic                       m_tlast;
  logic                       busy;
  logic                       overrun;
  logic                       clr_overrun;
  logic [15:0]                frame_cnt;

  mv_result_drain #(
    .NUM_NODES(NUM_NODES),
    .RES_W    (RES_W),
    .OUT_W    (OUT_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .capture    (capture),
    .res_bus    (res_bus),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .busy       (busy),
    .overrun    (overrun),
    .clr_overrun(clr_overrun),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_vec  = 0;
  int            n_err  = 0;
  int            exp_frames = 0;
  bit            rand_ready = 1'b0;
  logic [32:0]   sb [$];          // {tlast, tdata}
  logic [RES_W-1:0] stim [NUM_NODES];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [24:0] r);
    return {{7{r[24]}}, r};
  endfunction

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_tready = 1'($urandom_range(0, 1));
  endtask

  // Put stim[] on res_bus and raise capture; optionally queue the expected beats.
  task automatic start_capture(input bit push);
    for (int i = 0; i < NUM_NODES; i++) begin
      res_bus[i*RES_W +: RES_W] = stim[i];
      if (push) sb.push_back({(i == NUM_NODES - 1), sext(stim[i])});
    end
    capture = 1'b1;
  endtask

  task automatic wait_drain(input int budget, output int n);
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare handed-over beats and hold-stability during stalls.
  initial begin : monitor
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    logic [32:0] exp;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 64'(m_tvalid), 64'd1);
          check("stall_data", 64'(m_tdata), 64'(prev_data));
          check("stall_last", 64'(m_tlast), 64'(prev_last));
        end
        if (m_tvalid && m_tready) begin
          if (sb.size() == 0) begin
            check("beat_expected", 64'(sb.size()), 64'd1);
          end else begin
            exp = sb.pop_front();
            check("tdata", 64'(m_tdata), 64'(exp[31:0]));
            check("tlast", 64'(m_tlast), 64'(exp[32]));
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end
    end
  end

  initial begin : main
    int n;
    rstn        = 1'b0;
    capture     = 1'b0;
    res_bus     = '0;
    m_tready    = 1'b1;
    clr_overrun = 1'b0;
    #12;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    rstn = 1'b1;
    tick();

    // Basic frame, tready held high.
    for (int i = 0; i < NUM_NODES; i++) stim[i] = 25'(i + 1);
    start_capture(1'b1);
    tick();
    capture = 1'b0;
    check("lat_valid", 64'(m_tvalid), 64'd1);
    check("lat_node0", 64'(m_tdata), 64'd1);
    wait_drain(20, n);
    exp_frames++;
    check("basic_cycles", 64'(n), 64'd8);
    check("basic_busy_low", 64'(busy), 64'd0);
    check("basic_valid_low", 64'(m_tvalid), 64'd0);
    check("basic_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    // Sign extension at the edges of the 25-bit range.
    for (int i = 0; i < NUM_NODES; i++) stim[i] = '0;
    stim[0] = 25'h1000000;
    stim[1] = 25'h1FFFFFF;
    stim[2] = 25'h0FFFFFF;
    start_capture(1'b0);
    sb.push_back({1'b0, 32'hFF000000});
    sb.push_back({1'b0, 32'hFFFFFFFF});
    sb.push_back({1'b0, 32'h00FFFFFF});
    for (int i = 3; i < NUM_NODES; i++) sb.push_back({(i == NUM_NODES - 1), 32'h0});
    tick();
    capture = 1'b0;
    wait_drain(20, n);
    exp_frames++;

    // Random backpressure.
    for (int i = 0; i < NUM_NODES; i++) stim[i] = 25'(32'h100 * i);
    rand_ready = 1'b1;
    start_capture(1'b1);
    tick();
    capture = 1'b0;
    wait_drain(400, n);
    exp_frames++;
    rand_ready = 1'b0;
    m_tready   = 1'b1;
    tick();
    check("bp_busy_low", 64'(busy), 64'd0);
    check("bp_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    // Overrun: capture dropped at beat 3, then cleared.
    for (int i = 0; i < NUM_NODES; i++) stim[i] = 25'(32'h1000 + i);
    start_capture(1'b1);
    tick();
    capture = 1'b0;
    tick();
    tick();
    for (int i = 0; i < NUM_NODES; i++) stim[i] = 25'h1ABCDEF;
    start_capture(1'b0);
    tick();
    capture = 1'b0;
    check("ovr_set", 64'(overrun), 64'd1);
    wait_drain(20, n);
    exp_frames++;
    check("ovr_sticky", 64'(overrun), 64'd1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("ovr_clear", 64'(overrun), 64'd0);
    // Dropped capture and clear in the same cycle: set wins.
    for (int i = 0; i < NUM_NODES; i++) stim[i] = 25'(32'h1FFFF00 - i);
    start_capture(1'b1);
    tick();
    for (int i = 0; i < NUM_NODES; i++) stim[i] = 25'h0000055;
    start_capture(1'b0);
    clr_overrun = 1'b1;
    tick();
    capture     = 1'b0;
    clr_overrun = 1'b0;
    check("ovr_set_wins", 64'(overrun), 64'd1);
    wait_drain(20, n);
    exp_frames++;
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("ovr_clear2", 64'(overrun), 64'd0);

    // Back-to-back: second capture on the final beat of the first frame.
    for (int i = 0; i < NUM_NODES; i++) stim[i] = 25'(32'h20 + i);
    start_capture(1'b1);
    tick();
    capture = 1'b0;
    for (int i = 0; i < NUM_NODES - 1; i++) tick();
    check("b2b_at_last", 64'(m_tlast), 64'd1);
    for (int i = 0; i < NUM_NODES; i++) stim[i] = 25'(32'h1F00000 + 32'h11 * i);
    start_capture(1'b1);
    tick();
    capture = 1'b0;
    exp_frames++;
    check("b2b_no_bubble", 64'(m_tvalid), 64'd1);
    wait_drain(20, n);
    exp_frames++;
    check("b2b_cycles", 64'(n), 64'd8);
    check("b2b_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    check("b2b_overrun", 64'(overrun), 64'd0);

    // Asynchronous reset in the middle of a stalled frame with overrun set.
    m_tready = 1'b0;
    for (int i = 0; i < NUM_NODES; i++) stim[i] = 25'(32'h300 + i);
    start_capture(1'b1);
    tick();
    start_capture(1'b0);
    tick();
    capture = 1'b0;
    check("pre_rst_busy", 64'(busy), 64'd1);
    check("pre_rst_overrun", 64'(overrun), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_tvalid", 64'(m_tvalid), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_overrun", 64'(overrun), 64'd0);
    check("async_frame_cnt", 64'(frame_cnt), 64'd0);
    sb.delete();
    tick();
    tick();
    rstn     = 1'b1;
    m_tready = 1'b1;
    tick();
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_tvalid", 64'(m_tvalid), 64'd0);
    check("post_rst_frame_cnt", 64'(frame_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
